// File: rtl/s_bus_interface.sv
`default_nettype none
// ============================================================================
// s_bus_interface : once-per-CPU-cycle byte access router (ARAM / IPL / I/O)
// Rev 1.0
// ============================================================================
module s_bus_interface #(
  parameter int          CYCLE_DIV = 24,
  parameter logic [15:0] IPL_BASE  = 16'hFFC0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        apu_en,
  input  logic [15:0] bus_addr,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_opfetch,
  output logic [7:0]  bus_rdata,
  output logic [7:0]  op,
  output logic        cpu_en,
  input  logic        ipl_en,
  output logic [5:0]  ipl_addr,
  input  logic [7:0]  ipl_rdata,
  output logic [3:0]  io_addr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] stall_count
);

  localparam logic [7:0] C_DIV_LAST = 8'(CYCLE_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TGT_ARAM = 2'd0,
    TGT_IPL  = 2'd1,
    TGT_IO   = 2'd2
  } tgt_t;

  state_t      state_q, state_d;
  tgt_t        tgt_q, tgt_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        opfetch_q, opfetch_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  op_q, op_d;
  logic        mem_req_q, mem_req_d;
  logic        io_rd_q, io_rd_d;
  logic        io_wr_q, io_wr_d;
  logic [15:0] stall_q, stall_d;

  logic        div_last;
  logic        launch;
  logic        cpu_en_w;
  logic        stalled;
  logic        capture;
  logic [7:0]  cap_data;

  assign div_last = (div_q == C_DIV_LAST);
  assign launch   = apu_en && (state_q == ST_IDLE) && (div_q == 8'd0);
  assign cpu_en_w = !reset && apu_en && div_last && (state_q == ST_DONE);
  assign stalled  = apu_en && div_last && (state_q == ST_ACCESS);

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    div_d     = div_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    opfetch_d = opfetch_q;
    rdata_d   = rdata_q;
    op_d      = op_q;
    mem_req_d = mem_req_q;
    io_rd_d   = 1'b0;
    io_wr_d   = 1'b0;
    stall_d   = stall_q;
    capture   = 1'b0;
    cap_data  = 8'h00;

    // Divider parks on its last count until the access completes.
    if (cpu_en_w) begin
      div_d = 8'd0;
    end else if (apu_en && !div_last) begin
      div_d = div_q + 8'd1;
    end

    if (stalled && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          addr_d    = bus_addr;
          wr_d      = bus_wr;
          wdata_d   = bus_wdata;
          opfetch_d = bus_opfetch;
          state_d   = ST_ACCESS;
          if (bus_addr[15:4] == 12'h00F) begin
            tgt_d   = TGT_IO;
            io_rd_d = !bus_wr;
            io_wr_d = bus_wr;
          end else if (!bus_wr && ipl_en && (bus_addr >= IPL_BASE)) begin
            tgt_d = TGT_IPL;
          end else begin
            tgt_d     = TGT_ARAM;
            mem_req_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        case (tgt_q)
          TGT_IO: begin
            state_d  = ST_DONE;
            capture  = !wr_q;
            cap_data = io_rdata;
          end
          TGT_IPL: begin
            state_d  = ST_DONE;
            capture  = 1'b1;
            cap_data = ipl_rdata;
          end
          default: begin
            // Completion is not gated by apu_en: the handshake always finishes.
            if (mem_req_q && mem_ack) begin
              mem_req_d = 1'b0;
              state_d   = ST_DONE;
              capture   = !wr_q;
              cap_data  = mem_rdata;
            end
          end
        endcase
      end
      ST_DONE: begin
        if (cpu_en_w) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      rdata_d = cap_data;
      if (opfetch_q) begin
        op_d = cap_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tgt_q     <= TGT_ARAM;
      div_q     <= 8'd0;
      addr_q    <= 16'h0000;
      wr_q      <= 1'b0;
      wdata_q   <= 8'h00;
      opfetch_q <= 1'b0;
      rdata_q   <= 8'h00;
      op_q      <= 8'h00;
      mem_req_q <= 1'b0;
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      stall_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      div_q     <= div_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      opfetch_q <= opfetch_d;
      rdata_q   <= rdata_d;
      op_q      <= op_d;
      mem_req_q <= mem_req_d;
      io_rd_q   <= io_rd_d;
      io_wr_q   <= io_wr_d;
      stall_q   <= stall_d;
    end
  end

  assign bus_rdata   = rdata_q;
  assign op          = op_q;
  assign cpu_en      = cpu_en_w;
  assign ipl_addr    = addr_q[5:0];
  assign io_addr     = addr_q[3:0];
  assign io_rd       = io_rd_q;
  assign io_wr       = io_wr_q;
  assign io_wdata    = wdata_q;
  assign mem_addr    = addr_q;
  assign mem_req     = mem_req_q;
  assign mem_wr      = wr_q & mem_req_q;
  assign mem_wdata   = wdata_q;
  assign stall_count = stall_q;

endmodule
`default_nettype wire

// File: doc/s_bus_interface.md
Name: s_bus_interface

Overview:
- Memory-side stage directly upstream of the SPC700 controller.
- Once per CPU cycle it samples the datapath bus request and routes the single byte access to one of three targets: ARAM (req/ack handshake), IPL ROM, or the $F0-$FF I/O registers.
- It returns read data, latches the opcode on opcode fetches and produces the one-clk `cpu_en` strobe that advances the controller and datapath.
- ARAM latency beyond the nominal cycle stalls the CPU.

Parameters:
- CYCLE_DIV, 24, master clocks per nominal CPU cycle (legal 4..255).
- IPL_BASE, 16'hFFC0, first address of the 64-byte IPL ROM overlay.

Ports:
- clk  in  1  master clock.
- reset  in  1  synchronous, active-high.
- apu_en  in  1  global enable; divider frozen while low.
- bus_addr  in  16  access address from datapath.
- bus_wr  in  1  1 = write, 0 = read.
- bus_wdata  in  8  write data.
- bus_opfetch  in  1  read is an opcode fetch.
- bus_rdata  out  8  last read byte.
- op  out  8  current opcode to controller.
- cpu_en  out  1  one-clk CPU advance strobe.
- ipl_en  in  1  IPL overlay enabled.
- ipl_addr  out  6  IPL ROM address.
- ipl_rdata  in  8  IPL ROM data, valid 1 clk after ipl_addr.
- io_addr  out  4  I/O register index.
- io_rd  out  1  I/O read strobe.
- io_wr  out  1  I/O write strobe.
- io_wdata  out  8  I/O write data.
- io_rdata  in  8  I/O read data, valid 1 clk after io_rd.
- mem_addr  out  16  ARAM address.
- mem_req  out  1  ARAM request, level.
- mem_wr  out  1  ARAM write.
- mem_wdata  out  8  ARAM write data.
- mem_rdata  in  8  ARAM read data, valid with mem_ack.
- mem_ack  in  1  ARAM completion, 1 clk.
- stall_count  out  16  saturating count of stall clks.

Behaviour:
- Reset values:
  - All outputs 0, including cpu_en, mem_req, io_rd, io_wr, stall_count and bus_rdata.
  - op = 8'h00 (NOP).
  - Divider = 0, state = IDLE.
- Divider:
  - Counts 0..CYCLE_DIV-1 only when apu_en=1.
  - Holds at CYCLE_DIV-1 while stalled.
  - Wraps to 0 on the clk after cpu_en.
- Launch at divider=0 in IDLE with apu_en=1:
  - Register bus_addr, bus_wr, bus_wdata and bus_opfetch.
  - Decode the target with priority IO > IPL > ARAM.
- IO target (addr[15:4]=12'h00F):
  - Pulse io_rd or io_wr for exactly 1 clk.
  - io_addr = addr[3:0]; io_wdata = wdata.
  - A read captures io_rdata on the next clk.
  - The access is done 1 clk after launch.
  - IO writes are not written to ARAM.
- IPL target (read only, ipl_en=1, addr>=IPL_BASE):
  - ipl_addr = addr[5:0].
  - Capture ipl_rdata 1 clk after launch; the access is then done.
  - Writes to this range always go to ARAM.
- ARAM target:
  - mem_req rises on the launch clk + 1 and holds until mem_ack is sampled high.
  - mem_addr, mem_wr and mem_wdata are stable while mem_req=1.
  - mem_ack in the first req clk is legal.
  - mem_ack while mem_req=0 is ignored.
  - On ack: mem_req drops on the next clk, a read captures mem_rdata, and the access is done.
- Capture rules:
  - A read capture updates bus_rdata.
  - If opfetch is also set, op is updated with the same byte.
  - Writes leave bus_rdata and op unchanged.
- cpu_en:
  - Asserted for 1 clk at divider=CYCLE_DIV-1 when the access is done and apu_en=1.
  - If the access is not done at that point: stall, increment stall_count per clk (saturating at 16'hFFFF), and assert cpu_en on the clk after the done capture.
- apu_en:
  - Low freezes the divider and cpu_en.
  - An in-flight ARAM handshake still completes.
- States: IDLE → ACCESS → DONE → (cpu_en) → IDLE.
- Reset mid-access:
  - mem_req drops the next clk.
  - The ARAM side must tolerate an abandoned request.
  - A late mem_ack after reset is ignored.
- bus_* inputs are ignored outside the launch clk.

Test Plan:
- ARAM read, CYCLE_DIV=24, ack 3 clks after req, bus_addr=16'h1234, opfetch=1, mem_rdata=8'hE8 → mem_addr=16'h1234, op=8'hE8 and bus_rdata=8'hE8; cpu_en every 24 clks; stall_count=0.
- ARAM ack 40 clks after req → cpu_en 1 clk after the ack capture; stall_count increments by exactly the number of stalled clks; the next cycle restarts at divider 0.
- ipl_en=1, read 16'hFFC0 with ipl_rdata=8'hCD → ipl_addr=0, bus_rdata=8'hCD, mem_req never asserted. Repeat with ipl_en=0 → ARAM read. Write to 16'hFFC5 → ARAM write.
- Write 16'h00F4 with 8'h55 → single io_wr pulse with io_addr=4 and io_wdata=8'h55; no mem_req. Read 16'h00F7 with io_rdata=8'hAA → bus_rdata=8'hAA.
- Reset asserted while mem_req=1 → next clk mem_req=0, op=8'h00, cpu_en=0; a late mem_ack is ignored; the first launch follows on the first divider=0 after reset release.
- apu_en toggled low mid-cycle → divider holds and no cpu_en while low; after re-enable, cpu_en fires after the remaining count.
